ex_operand_stage: RTL
=====================

// Module: ex_operand_stage
// PURPOSE
// ID/EX pipeline register feeding the execute ALU (a, b, alu_control in, result/zero out).
// - Accepts decoded instructions from decode with a valid/ready handshake.
// - Resolves rs1/rs2 forwarding from EX/MEM and MEM/WB.
// - Selects the immediate as operand B when required.
// - Detects load-use hazards and inserts bubbles.
// - Presents registered ALU operands and control to the execute stage.
// PARAMETERS
// XLEN    32  datapath width of operands, immediates and forwarded results
// REGADDR 5   register index width; index 0 is x0 (hard zero, never forwarded)
// PORTS
// clk            in  1       rising-edge clock
// rst_n          in  1       asynchronous active-low reset
// id_valid       in  1       decode presents an instruction
// id_ready       out 1       stage accepts it this cycle
// id_rs1_addr    in  REGADDR source 1 index
// id_rs2_addr    in  REGADDR source 2 index
// id_rs1_data    in  XLEN    regfile read data for rs1
// id_rs2_data    in  XLEN    regfile read data for rs2
// id_imm         in  XLEN    sign-extended immediate
// id_use_imm     in  1       operand B = id_imm instead of rs2
// id_rd_addr     in  REGADDR destination index
// id_reg_write   in  1       instruction writes rd
// id_is_load     in  1       instruction is a load
// id_alu_control in  4       ALU opcode, passed through unchanged
// flush          in  1       kill held and incoming instruction (branch redirect)
// exm_reg_write  in  1       EX/MEM writes a register
// exm_rd_addr    in  REGADDR EX/MEM destination index
// exm_result     in  XLEN    EX/MEM result
// wb_reg_write   in  1       MEM/WB writes a register
// wb_rd_addr     in  REGADDR MEM/WB destination index
// wb_result      in  XLEN    MEM/WB writeback data
// ex_valid       out 1       execute holds a real instruction
// ex_ready       in  1       execute consumes it this cycle
// ex_a           out XLEN    ALU operand a
// ex_b           out XLEN    ALU operand b (forwarded rs2, or imm)
// ex_store_data  out XLEN    forwarded rs2 value, kept even when imm is used
// ex_alu_control out 4       ALU opcode
// ex_rd_addr     out REGADDR destination index
// ex_reg_write   out 1       destination write enable, gated by ex_valid
// ex_is_load     out 1       load marker for execute/memory stages
// BEHAVIOUR
// - Reset: ex_valid=0, all data/control outputs=0. The state machine goes to EMPTY.
// - State machine:
//   - EMPTY: no instruction held.
//   - FULL: instruction held, ex_valid=1.
//   - BUBBLE: one load-use bubble held, ex_valid=0.
// - advance = !ex_valid | ex_ready.
// - hazard = stage FULL & ex_is_load & ex_rd_addr!=0 & (ex_rd_addr==id_rs1_addr | (!id_use_imm & ex_rd_addr==id_rs2_addr)).
// - id_ready = advance & !hazard & !flush.
// - Accept (id_valid & id_ready): capture on the next edge.
//   - Go to FULL, latency 1 cycle.
//   - Back-to-back accepts give full throughput.
// - Hazard with advance: load moves on, stage becomes BUBBLE with ex_valid=0. Next cycle the dependent instruction is accepted.
// - Advance with no accept and no hazard: go to EMPTY, ex_valid=0.
// - !advance: all outputs hold their values. Downstream stalls freeze the whole pipe, so forwarded operands stay valid.
// - Forwarding per source, evaluated at accept:
//   - addr==0 gives 0.
//   - else exm_reg_write & exm_rd_addr==addr gives exm_result.
//   - else wb_reg_write & wb_rd_addr==addr gives wb_result.
//   - else regfile data.
//   - EX/MEM wins when both EX/MEM and MEM/WB match.
// - ex_b = id_use_imm ? id_imm : fwd_rs2. Widths are XLEN throughout with no extension inside the stage.
// - flush: on the next edge go to EMPTY, ex_valid=0, ex_reg_write=0.
//   - Overrides accept, hazard and stall.
//   - id_ready is 0 in the flush cycle.
// - ex_reg_write and ex_is_load are 0 whenever ex_valid=0, in both bubble and empty.
// - Reset asserted mid-operation: immediately return to the reset values. No partial state survives.
// TESTING
// - Reset: rst_n low mid-stream -> ex_valid=0 and ex_a=0 asynchronously; id_ready=1 after release.
// - Streaming: 4 back-to-back adds with ex_ready=1 -> each emerges 1 cycle later, and no gaps.
// - Forwarding: rs1=5, exm_rd=5 (exm_result=0x11), wb_rd=5 (wb_result=0x22) -> ex_a=0x11. rs1=0 with a matching rd=0 -> ex_a=0.
// - Load-use: a load with rd=3 held, next instruction has rs2=3, use_imm=0 -> id_ready=0 for 1 cycle, one bubble (ex_valid=0), then accept.
// - Immediate: use_imm=1, imm=0xFFFFFFF0, rs2 forwarded 0x7 -> ex_b=0xFFFFFFF0 and ex_store_data=0x7. Same rd as a held load with rs2 only -> no stall.
// - Stall/flush: ex_ready=0 for 3 cycles -> outputs stable. flush while FULL with id_valid=1 -> ex_valid=0 next cycle, and the incoming instruction is dropped.

Source files
------------

// File: rtl/ex_operand_if.sv
// Bundle of decode-side, forwarding and execute-side signals around the ID/EX operand stage.
interface ex_operand_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REGADDR = 5
);
  logic               id_valid;
  logic               id_ready;
  logic [REGADDR-1:0] id_rs1_addr;
  logic [REGADDR-1:0] id_rs2_addr;
  logic [XLEN-1:0]    id_rs1_data;
  logic [XLEN-1:0]    id_rs2_data;
  logic [XLEN-1:0]    id_imm;
  logic               id_use_imm;
  logic [REGADDR-1:0] id_rd_addr;
  logic               id_reg_write;
  logic               id_is_load;
  logic [3:0]         id_alu_control;
  logic               flush;
  logic               exm_reg_write;
  logic [REGADDR-1:0] exm_rd_addr;
  logic [XLEN-1:0]    exm_result;
  logic               wb_reg_write;
  logic [REGADDR-1:0] wb_rd_addr;
  logic [XLEN-1:0]    wb_result;
  logic               ex_valid;
  logic               ex_ready;
  logic [XLEN-1:0]    ex_a;
  logic [XLEN-1:0]    ex_b;
  logic [XLEN-1:0]    ex_store_data;
  logic [3:0]         ex_alu_control;
  logic [REGADDR-1:0] ex_rd_addr;
  logic               ex_reg_write;
  logic               ex_is_load;

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data, id_imm,
           id_use_imm, id_rd_addr, id_reg_write, id_is_load, id_alu_control, flush,
           exm_reg_write, exm_rd_addr, exm_result, wb_reg_write, wb_rd_addr, wb_result,
           ex_ready,
    output id_ready, ex_valid, ex_a, ex_b, ex_store_data, ex_alu_control, ex_rd_addr,
           ex_reg_write, ex_is_load
  );

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data, id_imm,
           id_use_imm, id_rd_addr, id_reg_write, id_is_load, id_alu_control, flush,
           exm_reg_write, exm_rd_addr, exm_result, wb_reg_write, wb_rd_addr, wb_result,
           ex_ready,
    input  id_ready, ex_valid, ex_a, ex_b, ex_store_data, ex_alu_control, ex_rd_addr,
           ex_reg_write, ex_is_load
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register: operand forwarding, immediate select and load-use bubble insertion.
module ex_operand_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REGADDR = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  ex_operand_if.slave  bus
);

  localparam int unsigned CTRLW = 4;

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_FULL   = 2'd1,
    S_BUBBLE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0]    a_q, a_d;
  logic [XLEN-1:0]    b_q, b_d;
  logic [XLEN-1:0]    store_q, store_d;
  logic [CTRLW-1:0]   alu_q, alu_d;
  logic [REGADDR-1:0] rd_q, rd_d;
  logic               rw_q, rw_d;
  logic               load_q, load_d;

  logic               full;
  logic               advance;
  logic               hazard;
  logic               id_ready_c;
  logic               accept;
  logic [XLEN-1:0]    fwd_rs1;
  logic [XLEN-1:0]    fwd_rs2;

  // x0 never forwards; EX/MEM is younger than MEM/WB so it takes priority.
  function automatic logic [XLEN-1:0] forward(
    input logic [REGADDR-1:0] addr,
    input logic [XLEN-1:0]    rf_data,
    input logic               exm_we,
    input logic [REGADDR-1:0] exm_rd,
    input logic [XLEN-1:0]    exm_val,
    input logic               wb_we,
    input logic [REGADDR-1:0] wb_rd,
    input logic [XLEN-1:0]    wb_val
  );
    if (addr == '0)                        return '0;
    else if (exm_we && (exm_rd == addr))   return exm_val;
    else if (wb_we && (wb_rd == addr))     return wb_val;
    else                                   return rf_data;
  endfunction

  assign fwd_rs1 = forward(bus.id_rs1_addr, bus.id_rs1_data, bus.exm_reg_write,
                           bus.exm_rd_addr, bus.exm_result, bus.wb_reg_write,
                           bus.wb_rd_addr, bus.wb_result);
  assign fwd_rs2 = forward(bus.id_rs2_addr, bus.id_rs2_data, bus.exm_reg_write,
                           bus.exm_rd_addr, bus.exm_result, bus.wb_reg_write,
                           bus.wb_rd_addr, bus.wb_result);

  assign full    = (state_q == S_FULL);
  assign advance = !full || bus.ex_ready;
  // A held load whose rd feeds a register source of the incoming instruction.
  assign hazard  = full && load_q && (rd_q != '0) &&
                   ((rd_q == bus.id_rs1_addr) ||
                    (!bus.id_use_imm && (rd_q == bus.id_rs2_addr)));
  assign id_ready_c = advance && !hazard && !bus.flush;
  assign accept     = bus.id_valid && id_ready_c;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  // Next-state logic; flush overrides stall, accept and hazard.
  always_comb begin
    state_d = state_q;
    if (bus.flush)      state_d = S_EMPTY;
    else if (!advance)  state_d = state_q;
    else if (accept)    state_d = S_FULL;
    else if (hazard)    state_d = S_BUBBLE;
    else                state_d = S_EMPTY;
  end

  // Payload next values; write/load markers drop whenever the slot is not a real instruction.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    store_d = store_q;
    alu_d   = alu_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    load_d  = load_q;
    if (accept) begin
      a_d     = fwd_rs1;
      b_d     = bus.id_use_imm ? bus.id_imm : fwd_rs2;
      store_d = fwd_rs2;
      alu_d   = bus.id_alu_control;
      rd_d    = bus.id_rd_addr;
      rw_d    = bus.id_reg_write;
      load_d  = bus.id_is_load;
    end
    if (state_d != S_FULL) begin
      rw_d   = 1'b0;
      load_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      store_q <= '0;
      alu_q   <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      store_q <= store_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      load_q  <= load_d;
    end
  end

  assign bus.id_ready       = id_ready_c;
  assign bus.ex_valid       = full;
  assign bus.ex_a           = a_q;
  assign bus.ex_b           = b_q;
  assign bus.ex_store_data  = store_q;
  assign bus.ex_alu_control = alu_q;
  assign bus.ex_rd_addr     = rd_q;
  assign bus.ex_reg_write   = rw_q;
  assign bus.ex_is_load     = load_q;

endmodule
